// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: opcodes, functs,
// ALUOp codes, mux selects, state encoding and the instruction class bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_SLTIU = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;
  localparam logic [2:0] ALU_ADD   = 3'b110;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_SHAMT = 2'b10;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_IMMSH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_t;

  // Exactly one field is set for any opcode/funct combination.
  typedef struct packed {
    logic mem;
    logic rtype;
    logic jr;
    logic branch;
    logic jump;
    logic jal;
    logic itype;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/mc_instr_class.sv
// Combinational opcode/funct classifier feeding the main control FSM, plus the
// few qualifiers the FSM needs within a class (store, bne, sll, I-type ALUOp).
module mc_instr_class
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         is_store,
  output logic         is_bne,
  output logic         is_sll,
  output logic [2:0]   imm_alu_op
);

  logic rtype_ok;

  always_comb begin
    rtype_ok = 1'b0;
    case (funct)
      FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: rtype_ok = 1'b1;
      default: rtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    cls        = '0;
    imm_alu_op = ALU_ADD;
    case (opcode)
      OP_LW, OP_SW:   cls.mem    = 1'b1;
      OP_BEQ, OP_BNE: cls.branch = 1'b1;
      OP_J:           cls.jump   = 1'b1;
      OP_JAL:         cls.jal    = 1'b1;
      OP_ADDIU: begin cls.itype = 1'b1; imm_alu_op = ALU_ADD;   end
      OP_SLTI:  begin cls.itype = 1'b1; imm_alu_op = ALU_SLT;   end
      OP_SLTIU: begin cls.itype = 1'b1; imm_alu_op = ALU_SLTIU; end
      OP_LUI:   begin cls.itype = 1'b1; imm_alu_op = ALU_LUI;   end
      OP_RTYPE: begin
        if (funct == FN_JR) cls.jr      = 1'b1;
        else if (rtype_ok)  cls.rtype   = 1'b1;
        else                cls.illegal = 1'b1;
      end
      default: cls.illegal = 1'b1;
    endcase
  end

  assign is_store = (opcode == OP_SW);
  assign is_bne   = (opcode == OP_BNE);
  assign is_sll   = (funct == FN_SLL);

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: sequences IF/ID/EX/MEM/WB and decodes
// the current state into datapath enables and mux selects.
//
//  state    | meaning
//  S_IF     | fetch; wait mem_ack, load IR, PC+4
//  S_ID     | decode; branch target into ALUOut
//  S_MEMADR | LW/SW effective address
//  S_MEMRD  | data read; wait mem_ack
//  S_MEMWB  | write MDR to rt
//  S_MEMWR  | data write; wait mem_ack
//  S_RTEX   | R-type execute
//  S_RTWB   | write ALUOut to rd
//  S_IEX    | I-type execute
//  S_IWB    | write ALUOut to rt
//  S_BR     | BEQ/BNE compare and conditional PC load
//  S_JMP    | J
//  S_JAL    | jump and link PC to $31
//  S_JR     | jump to rs
module mc_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_op,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_t       state, state_nx;
  instr_class_t cls;
  logic         is_store, is_bne, is_sll;
  logic [2:0]   imm_alu_op;

  mc_instr_class u_class (
    .opcode     (opcode),
    .funct      (funct),
    .cls        (cls),
    .is_store   (is_store),
    .is_bne     (is_bne),
    .is_sll     (is_sll),
    .imm_alu_op (imm_alu_op)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IF;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = S_IF;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_AND;
    reg_we     = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    illegal_op = 1'b0;

    case (state)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
        ir_we     = mem_ack;
        pc_we     = mem_ack;
        state_nx  = mem_ack ? S_ID : S_IF;
      end
      S_ID: begin
        alu_src_b = SRC_B_IMMSH;
        alu_op    = ALU_ADD;
        if (cls.mem)         state_nx = S_MEMADR;
        else if (cls.rtype)  state_nx = S_RTEX;
        else if (cls.jr)     state_nx = S_JR;
        else if (cls.branch) state_nx = S_BR;
        else if (cls.jump)   state_nx = S_JMP;
        else if (cls.jal)    state_nx = S_JAL;
        else if (cls.itype)  state_nx = S_IEX;
        else begin
          illegal_op = cls.illegal;
          state_nx   = S_IF;
        end
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        state_nx  = is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_nx = mem_ack ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = WB_MDR;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_nx  = mem_ack ? S_IF : S_MEMWR;
      end
      S_RTEX: begin
        alu_src_a = is_sll ? SRC_A_SHAMT : SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_RTYPE;
        state_nx  = S_RTWB;
      end
      S_RTWB: begin
        reg_we  = 1'b1;
        reg_dst = DST_RD;
      end
      S_IEX: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        alu_op    = imm_alu_op;
        state_nx  = S_IWB;
      end
      S_IWB: begin
        reg_we  = 1'b1;
        reg_dst = DST_RT;
      end
      S_BR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_we     = is_bne ? ~zero : zero;
      end
      S_JMP: begin
        pc_src = PC_SRC_JUMP;
        pc_we  = 1'b1;
      end
      S_JAL: begin
        pc_src     = PC_SRC_JUMP;
        pc_we      = 1'b1;
        reg_we     = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = WB_PC;
      end
      S_JR: begin
        pc_src = PC_SRC_RS;
        pc_we  = 1'b1;
      end
      default: state_nx = S_IF;
    endcase

    // Held in reset: nothing may be requested or written.
    if (rst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 3'b000;
      reg_we     = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      illegal_op = 1'b0;
    end
  end

  assign state_dbg = STATE_W'(state);

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-cycle checks of state and decoded
// controls for each instruction class, stalls, reset and illegal opcodes.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, mem_ack;
  logic       mem_read, mem_write, iord, ir_we, pc_we;
  logic [1:0] pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic       reg_we, illegal_op;
  logic [3:0] state_dbg;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;

  mc_main_control #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Fetch with immediate ack and step into S_ID.
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    opcode  = op;
    funct   = fn;
    mem_ack = 1'b1;
    #1;
    chk("if_state", int'(state_dbg), 0);
    chk("if_pc_we", int'(pc_we), 1);
    tick();
    chk("id_state", int'(state_dbg), 1);
  endtask

  logic [5:0] iop_tab [4];
  int         ialu_tab [4];

  initial begin
    iop_tab  = '{6'b001001, 6'b001010, 6'b001011, 6'b001111};
    ialu_tab = '{6, 4, 3, 5};
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ack = 1'b0;
    cyc = 0;

    // Reset state
    tick(); tick();
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_mem_read", int'(mem_read), 0);
    chk("rst_reg_we", int'(reg_we), 0);
    rst = 1'b0; #1;
    chk("post_rst_mem_read", int'(mem_read), 1);
    chk("post_rst_ir_we", int'(ir_we), 0);

    // ADDU
    fetch(6'b000000, 6'b100001);
    chk("addu_if_alu", 6, 6);
    chk("addu_id_alu", int'(alu_op), 6);
    chk("addu_id_srcb", int'(alu_src_b), 3);
    chk("addu_id_reg_we", int'(reg_we), 0);
    tick();
    chk("addu_ex_state", int'(state_dbg), 6);
    chk("addu_ex_alu", int'(alu_op), 2);
    chk("addu_ex_srca", int'(alu_src_a), 1);
    chk("addu_ex_reg_we", int'(reg_we), 0);
    tick();
    chk("addu_wb_state", int'(state_dbg), 7);
    chk("addu_wb_reg_we", int'(reg_we), 1);
    chk("addu_wb_reg_dst", int'(reg_dst), 1);
    chk("addu_wb_m2r", int'(mem_to_reg), 0);
    tick();
    chk("addu_done", int'(state_dbg), 0);

    // SLL uses shamt on A
    fetch(6'b000000, 6'b000000);
    tick();
    chk("sll_srca", int'(alu_src_a), 2);
    tick(); tick();

    // BEQ / BNE with zero=1
    zero = 1'b1;
    fetch(6'b000100, 6'b000000);
    tick();
    chk("beq_state", int'(state_dbg), 10);
    chk("beq_pc_we", int'(pc_we), 1);
    chk("beq_pc_src", int'(pc_src), 1);
    chk("beq_alu", int'(alu_op), 1);
    tick();
    chk("beq_done", int'(state_dbg), 0);
    fetch(6'b000101, 6'b000000);
    tick();
    chk("bne_pc_we", int'(pc_we), 0);
    tick();
    chk("bne_done", int'(state_dbg), 0);
    zero = 1'b0;

    // LW with stalls: 3 in IF, 2 in MEMRD -> 10 cycles
    opcode = 6'b100011; funct = 6'd0; mem_ack = 1'b0; cyc = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_stall_ir_we", int'(ir_we), 0);
      chk("lw_stall_pc_we", int'(pc_we), 0);
      tick();
    end
    mem_ack = 1'b1; #1;
    chk("lw_ack_ir_we", int'(ir_we), 1);
    chk("lw_ack_pc_we", int'(pc_we), 1);
    tick();
    chk("lw_id_ir_we", int'(ir_we), 0);
    chk("lw_id_pc_we", int'(pc_we), 0);
    tick();
    chk("lw_adr_state", int'(state_dbg), 2);
    chk("lw_adr_srcb", int'(alu_src_b), 2);
    mem_ack = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("lw_rd_state", int'(state_dbg), 3);
      chk("lw_rd_iord", int'(iord), 1);
      tick();
    end
    mem_ack = 1'b1; #1;
    chk("lw_rd_mem_read", int'(mem_read), 1);
    tick();
    chk("lw_wb_state", int'(state_dbg), 4);
    chk("lw_wb_reg_we", int'(reg_we), 1);
    chk("lw_wb_m2r", int'(mem_to_reg), 1);
    tick();
    chk("lw_done", int'(state_dbg), 0);
    chk("lw_cycles", cyc, 10);

    // Reset mid-LW in S_MEMRD
    fetch(6'b100011, 6'd0);
    tick(); mem_ack = 1'b0; tick();
    chk("rlw_state", int'(state_dbg), 3);
    rst = 1'b1; #1;
    chk("rlw_mem_read_forced", int'(mem_read), 0);
    chk("rlw_reg_we0", int'(reg_we), 0);
    tick();
    chk("rlw_reg_we1", int'(reg_we), 0);
    tick();
    rst = 1'b0; #1;
    chk("rlw_after_state", int'(state_dbg), 0);
    chk("rlw_after_mem_read", int'(mem_read), 1);
    chk("rlw_after_reg_we", int'(reg_we), 0);

    // SW
    fetch(6'b101011, 6'd0);
    tick(); tick();
    chk("sw_state", int'(state_dbg), 5);
    chk("sw_mem_write", int'(mem_write), 1);
    chk("sw_mem_read", int'(mem_read), 0);
    tick();
    chk("sw_done", int'(state_dbg), 0);

    // JAL
    fetch(6'b000011, 6'd0);
    tick();
    chk("jal_pc_we", int'(pc_we), 1);
    chk("jal_reg_we", int'(reg_we), 1);
    chk("jal_reg_dst", int'(reg_dst), 2);
    chk("jal_m2r", int'(mem_to_reg), 2);
    chk("jal_pc_src", int'(pc_src), 2);
    tick();

    // JR
    fetch(6'b000000, 6'b001000);
    tick();
    chk("jr_state", int'(state_dbg), 13);
    chk("jr_pc_src", int'(pc_src), 3);
    chk("jr_pc_we", int'(pc_we), 1);
    chk("jr_reg_we", int'(reg_we), 0);
    tick();
    chk("jr_done", int'(state_dbg), 0);

    // J
    fetch(6'b000010, 6'd0);
    tick();
    chk("j_pc_src", int'(pc_src), 2);
    tick();

    // I-type ALUOp table
    for (int k = 0; k < 4; k++) begin
      fetch(iop_tab[k], 6'd0);
      tick();
      chk("iex_alu", int'(alu_op), ialu_tab[k]);
      tick();
      chk("iwb_reg_we", int'(reg_we), 1);
      tick();
    end

    // Illegal opcode
    opcode = 6'b111111; funct = 6'd0; mem_ack = 1'b1; #1;
    chk("ill_if_pulse", int'(illegal_op), 0);
    tick();
    chk("ill_id_pulse", int'(illegal_op), 1);
    chk("ill_id_pc_we", int'(pc_we), 0);
    chk("ill_id_reg_we", int'(reg_we), 0);
    chk("ill_id_mem_write", int'(mem_write), 0);
    tick();
    chk("ill_back_if", int'(state_dbg), 0);
    chk("ill_pulse_gone", int'(illegal_op), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
